// File: rtl/dom_rand_supplier.sv
// Fresh-randomness source for the DOM GF(2^2) multipliers: a 64-bit LFSR with seed
// handshake, warm-up and reseed interval, emitting packed Z (remask) and B (blinding) words.
module dom_rand_supplier #(
    parameter int unsigned SHARES          = 2,
    parameter int unsigned WARMUP          = 64,
    parameter int unsigned RESEED_INTERVAL = 1024
) (
    input  logic                                ClkxCI,
    input  logic                                RstxRI,
    input  logic [63:0]                         SeedxDI,
    input  logic                                SeedValidxSI,
    output logic                                SeedReadyxSO,
    output logic                                NeedSeedxSO,
    output logic [SHARES*(SHARES-1)-1:0]        _ZxDO,
    output logic [2*SHARES-1:0]                 _BxDO,
    output logic                                RandValidxSO,
    input  logic                                RandReadyxSI
);

    localparam int unsigned SZ = SHARES * (SHARES - 1);
    localparam int unsigned SB = 2 * SHARES;
    localparam int unsigned RW = SZ + SB;
    localparam int unsigned CW = $clog2(RESEED_INTERVAL + 1);
    localparam int unsigned WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          r_state,     w_state;
    logic [63:0]     r_lfsr,      w_lfsr;
    logic [CW-1:0]   r_word_cnt,  w_word_cnt;
    logic [WW-1:0]   r_warm_cnt,  w_warm_cnt;
    logic [SZ-1:0]   r_z,         w_z;
    logic [SB-1:0]   r_b,         w_b;
    logic            r_valid,     w_valid;
    logic            r_need_seed, w_need_seed;
    logic [63:0]     w_adv;

    // One advance: RW unrolled LFSR steps.
    function automatic logic [63:0] f_advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < int'(RW); i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    assign w_adv = f_advance(r_lfsr);

    always_comb begin
        w_state     = r_state;
        w_lfsr      = r_lfsr;
        w_word_cnt  = r_word_cnt;
        w_warm_cnt  = r_warm_cnt;
        w_z         = r_z;
        w_b         = r_b;
        w_valid     = r_valid;

        case (r_state)
            S_WARM: begin
                if (r_warm_cnt == WW'(WARMUP)) begin
                    w_state = S_RUN;
                end else begin
                    w_lfsr     = w_adv;
                    w_warm_cnt = r_warm_cnt + WW'(1);
                end
            end
            S_RUN: begin
                if (!r_valid) begin
                    w_lfsr  = w_adv;
                    w_z     = w_adv[SZ-1:0];
                    w_b     = w_adv[RW-1:SZ];
                    w_valid = 1'b1;
                end else if (RandReadyxSI) begin
                    w_word_cnt = r_word_cnt + CW'(1);
                    if (r_word_cnt == CW'(RESEED_INTERVAL - 1)) begin
                        // Seed exhausted: drop the stream until a new seed arrives.
                        w_valid = 1'b0;
                        w_z     = '0;
                        w_b     = '0;
                        w_state = S_IDLE;
                    end else begin
                        w_lfsr  = w_adv;
                        w_z     = w_adv[SZ-1:0];
                        w_b     = w_adv[RW-1:SZ];
                        w_valid = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        // A seed offer always wins and aborts whatever word is pending.
        if (SeedValidxSI) begin
            w_lfsr     = (SeedxDI == 64'h0) ? 64'h1 : SeedxDI;
            w_word_cnt = '0;
            w_warm_cnt = '0;
            w_valid    = 1'b0;
            w_z        = '0;
            w_b        = '0;
            w_state    = S_WARM;
        end

        w_need_seed = (w_state == S_IDLE);
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_state     <= S_IDLE;
            r_lfsr      <= 64'h0;
            r_word_cnt  <= '0;
            r_warm_cnt  <= '0;
            r_z         <= '0;
            r_b         <= '0;
            r_valid     <= 1'b0;
            r_need_seed <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_lfsr      <= w_lfsr;
            r_word_cnt  <= w_word_cnt;
            r_warm_cnt  <= w_warm_cnt;
            r_z         <= w_z;
            r_b         <= w_b;
            r_valid     <= w_valid;
            r_need_seed <= w_need_seed;
        end
    end

    assign SeedReadyxSO = 1'b1;
    assign NeedSeedxSO  = r_need_seed;
    assign _ZxDO        = r_z;
    assign _BxDO        = r_b;
    assign RandValidxSO = r_valid;

endmodule

// File: tb/tb_dom_rand_supplier.sv
// Scoreboard bench for dom_rand_supplier: two configurations, expected word streams
// computed from the LFSR rule and popped by monitors on every transfer.
module tb_dom_rand_supplier;

    localparam int unsigned RW_A = 6;
    localparam int unsigned RW_B = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] seed_a, seed_b;
    logic        sv_a, sv_b, sr_a, sr_b, ns_a, ns_b, v_a, v_b, rdy_a, rdy_b;
    logic [1:0]  z_a;
    logic [3:0]  b_a;
    logic [5:0]  z_b;
    logic [5:0]  b_b;

    dom_rand_supplier #(.SHARES(2), .WARMUP(0), .RESEED_INTERVAL(4)) u_a (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed_a), .SeedValidxSI(sv_a),
        .SeedReadyxSO(sr_a), .NeedSeedxSO(ns_a), ._ZxDO(z_a), ._BxDO(b_a),
        .RandValidxSO(v_a), .RandReadyxSI(rdy_a)
    );

    dom_rand_supplier #(.SHARES(3), .WARMUP(64), .RESEED_INTERVAL(1024)) u_b (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed_b), .SeedValidxSI(sv_b),
        .SeedReadyxSO(sr_b), .NeedSeedxSO(ns_b), ._ZxDO(z_b), ._BxDO(b_b),
        .RandValidxSO(v_b), .RandReadyxSI(rdy_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          words_a = 0;
    int          words_b = 0;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: n single steps of the Fibonacci LFSR.
    function automatic logic [63:0] lfsr_steps(input logic [63:0] s, input int unsigned n);
        logic [63:0] t;
        t = s;
        for (int unsigned i = 0; i < n; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        return t;
    endfunction

    // Expected stream for one seed: skip the warm-up, then one word per advance.
    task automatic push_seed(input bit which, input logic [63:0] seed);
        logic [63:0] s;
        int unsigned rw, w, n;
        s  = (seed == 64'h0) ? 64'h1 : seed;
        rw = which ? RW_B : RW_A;
        w  = which ? 64 : 0;
        n  = which ? 1024 : 4;
        s  = lfsr_steps(s, rw * w);
        if (which) exp_b.delete(); else exp_a.delete();
        for (int unsigned k = 0; k < n; k++) begin
            s = lfsr_steps(s, rw);
            if (which) exp_b.push_back(s & ((64'h1 << rw) - 64'h1));
            else       exp_a.push_back(s & ((64'h1 << rw) - 64'h1));
        end
    endtask

    task automatic do_seed(input bit which, input logic [63:0] val);
        @(posedge clk); #1;
        if (which) begin seed_b = val; sv_b = 1'b1; end
        else       begin seed_a = val; sv_a = 1'b1; end
        @(posedge clk); #1;
        if (which) sv_b = 1'b0; else sv_a = 1'b0;
        push_seed(which, val);
    endtask

    // Edges after the accept edge until valid shows (sampled at negedges).
    task automatic latency(input bit which, output int k);
        k = 0;
        forever begin
            @(negedge clk);
            if ((which ? v_b : v_a) || k >= 200) break;
            k++;
        end
    endtask

    logic        held_a, held_b;
    logic [63:0] hw_a, hw_b, e_a, e_b;

    always @(negedge clk) begin
        if (rst) begin
            held_a = 1'b0;
        end else begin
            if (held_a) begin
                chk("a_hold_valid", 64'(v_a), 64'd1);
                chk("a_hold_word", 64'({b_a, z_a}), hw_a);
            end
            if (v_a && rdy_a) begin
                if (exp_a.size() == 0) chk("a_extra_word", 64'(exp_a.size()), 64'd1);
                else begin
                    e_a = exp_a.pop_front();
                    chk("a_word", 64'({b_a, z_a}), e_a);
                    words_a++;
                end
            end
            held_a = v_a && !rdy_a && !sv_a;
            hw_a   = 64'({b_a, z_a});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held_b = 1'b0;
        end else begin
            if (held_b) begin
                chk("b_hold_valid", 64'(v_b), 64'd1);
                chk("b_hold_word", 64'({b_b, z_b}), hw_b);
            end
            if (v_b && rdy_b) begin
                if (exp_b.size() == 0) chk("b_extra_word", 64'(exp_b.size()), 64'd1);
                else begin
                    e_b = exp_b.pop_front();
                    chk("b_word", 64'({b_b, z_b}), e_b);
                    words_b++;
                end
            end
            held_b = v_b && !rdy_b && !sv_b;
            hw_b   = 64'({b_b, z_b});
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_a_valid"}, 64'(v_a), 64'd0);
        chk({nm, "_a_word"},  64'({b_a, z_a}), 64'd0);
        chk({nm, "_a_need"},  64'(ns_a), 64'd1);
        chk({nm, "_a_ready"}, 64'(sr_a), 64'd1);
        chk({nm, "_b_valid"}, 64'(v_b), 64'd0);
        chk({nm, "_b_word"},  64'({b_b, z_b}), 64'd0);
        chk({nm, "_b_need"},  64'(ns_b), 64'd1);
        chk({nm, "_b_ready"}, 64'(sr_b), 64'd1);
    endtask

    initial begin
        int k, cycles, target, w0;
        logic [63:0] sd;
        rst = 1'b1; sv_a = 1'b0; sv_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        seed_a = 64'h0; seed_b = 64'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        repeat (5) @(negedge clk);
        chk_idle("noseed");

        // Known seed, no warm-up, consumer stalled.
        do_seed(1'b0, 64'h8000_0000_0000_0000);
        latency(1'b0, k);
        chk("a_latency_seed8", 64'(k), 64'd2);
        chk("a_first_z", 64'(z_a), 64'd0);
        chk("a_first_b", 64'(b_a), 64'h8);
        repeat (10) @(negedge clk);
        chk("a_held_word", 64'({b_a, z_a}), 64'h20);
        w0 = words_a;
        @(posedge clk); #1 rdy_a = 1'b1;
        repeat (8) @(negedge clk);
        chk("a_interval_words", 64'(words_a - w0), 64'd4);
        chk("a_after_interval_valid", 64'(v_a), 64'd0);
        chk("a_after_interval_need", 64'(ns_a), 64'd1);
        repeat (5) @(negedge clk);
        chk("a_no_fifth_word", 64'(words_a - w0), 64'd4);

        // Zero seed behaves as seed 1.
        @(posedge clk); #1 rdy_a = 1'b0;
        do_seed(1'b0, 64'h0);
        latency(1'b0, k);
        chk("a_latency_seed0", 64'(k), 64'd2);
        chk("a_seed0_word", 64'({b_a, z_a}), 64'h0);
        chk("a_seed0_need", 64'(ns_a), 64'd0);
        w0 = words_a;
        @(posedge clk); #1 rdy_a = 1'b1;
        repeat (8) @(negedge clk);
        chk("a_seed0_words", 64'(words_a - w0), 64'd4);
        chk("a_seed0_queue", 64'(exp_a.size()), 64'd0);

        // Warm-up 64, then reseed while a transfer is taking place.
        rdy_b = 1'b1;
        do_seed(1'b1, {$urandom, $urandom});
        latency(1'b1, k);
        chk("b_latency_first", 64'(k), 64'd66);
        repeat (20) @(negedge clk);
        chk("b_valid_before_reseed", 64'(v_b), 64'd1);
        do_seed(1'b1, {$urandom, $urandom});
        latency(1'b1, k);
        chk("b_latency_reseed", 64'(k), 64'd66);

        // Random back-pressure across several reseed intervals.
        target = words_b + 10000;
        cycles = 0;
        while (words_b < target && cycles < 60000) begin
            @(posedge clk); #1;
            cycles++;
            sd = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
            if (ns_b) do_seed(1'b1, sd);
            else if ($urandom_range(0, 2999) == 0) do_seed(1'b1, sd);
            else rdy_b = ($urandom_range(0, 99) < 55);
        end
        chk("b_word_budget", 64'(words_b >= target), 64'd1);

        // Reset in the middle of a stream.
        @(posedge clk); #1 rdy_b = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_b_valid", 64'(v_b), 64'd0);
        chk("rst_mid_b_word", 64'({b_b, z_b}), 64'd0);
        chk("rst_mid_b_need", 64'(ns_b), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
